stack36: RTL and testbench
==========================

Name: stack36

Overview:
- Hardware LIFO of 36-bit words. Sits directly upstream of the 36-bit register stage: the popped word and its valid strobe drive that register's D and set inputs.
- Keeps its own stack pointer, which moves up and down the way the register's inc/dec does.
- Serves the CPU's call/return and operand stack.

Parameters:
WIDTH, 36, data word width
DEPTH, 16, number of entries; power of two, minimum 2
PTR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: empties stack, drops pop_valid
push  in  1  write request
push_data  in  WIDTH  word to push
pop  in  1  read request
pop_data  out  WIDTH  popped word (feeds register D)
pop_valid  out  1  one-cycle strobe, pop_data valid (feeds register set)
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  PTR_W+1  current occupancy, 0..DEPTH
err  out  1  sticky overflow/underflow flag; present only with STACK36_ERR_EN

Behaviour:
- Reset (rst_n low, async): count=0, pop_valid=0, pop_data=0, empty=1, full=0, err=0. Storage array is not reset.
- Reset asserted mid-operation aborts any in-flight pop; pop_valid goes low immediately.
- Storage: array mem[0..DEPTH-1]; the top of stack is mem[count-1].
- Push accepted when push=1 and (full=0, or pop is also accepted the same cycle).
  - Writes mem[count] and increments count on the next rising edge.
- Pop accepted when pop=1 and empty=0.
  - pop_data is loaded with mem[count-1] and count decrements on the same edge.
  - pop_valid=1 for exactly one cycle after the accepting edge (latency 1).
  - pop_data holds its value until the next accepted pop.
- Simultaneous accepted push and pop: pop_data gets the old top; push_data overwrites mem[count-1]; count unchanged; pop_valid=1.
- Push+pop when empty: the pop is rejected and the push proceeds normally (count becomes 1, pop_valid=0).
- Push+pop when full: both are accepted (replace top); count stays at DEPTH.
- Push when full with no pop: ignored; count, mem and full are unchanged.
- Pop when empty: ignored; pop_valid=0 and pop_data is held.
- clr=1: count=0 and pop_valid=0 next edge.
  - clr has priority over push and pop in the same cycle; err clears too.
- full and empty are combinational decodes of registered count; they never glitch on inputs.
- No count wrap: count is saturated by the accept rules above and never exceeds DEPTH or goes below 0.
- X on push/pop while rst_n is low has no effect.

Optional Feature:
- Macro: STACK36_ERR_EN.
- Defined:
  - err port exists.
  - err sets on the edge following a rejected push (full, no pop) or a rejected pop (empty).
  - err stays high until clr or rst_n.
  - Rejected operations still have no other effect.
- Undefined:
  - No err port and no error logic.
  - Rejected operations are silently dropped.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, then release -> count=0, empty=1, full=0, pop_valid=0, pop_data=0.
2. Push 0x123456789, then 0xFEDCBA987, then pop twice -> pop_data=0xFEDCBA987 with pop_valid=1 one cycle after the first pop, then 0x123456789; count 2->1->0; empty=1 at end.
3. Push 16 words (i*0x111111111, i=0..15) -> full=1, count=16. Then a 17th push of 0xAAAAAAAAA -> ignored, count=16. Then pop -> 0xFFFFFFFFF. (err=1 with STACK36_ERR_EN.)
4. With 3 entries on the stack, top=0x000000003, push 0x00000000F and pop in the same cycle -> pop_data=0x000000003, count stays 3. The next pop returns 0x00000000F.
5. With the stack empty, pop -> pop_valid stays 0 and pop_data is unchanged (err=1 with the macro). Then assert clr -> err=0.
6. Push 5 words, then pulse rst_n low asynchronously between clock edges in the same cycle a pop is asserted -> count=0 and pop_valid=0 immediately. No pop_valid pulse follows reset release.

Source files
------------

// File: rtl/stack36_if.sv
// Push/pop handshake bundle between a stack36 LIFO and its user.
// The err wire exists only when STACK36_ERR_EN is defined.
interface stack36_if #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             clr;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
`ifdef STACK36_ERR_EN
  logic             err;
`endif

  modport master (
    output clr, push, push_data, pop,
    input  pop_data, pop_valid, full, empty, count
`ifdef STACK36_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  clr, push, push_data, pop,
    output pop_data, pop_valid, full, empty, count
`ifdef STACK36_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/stack36.sv
// 36-bit hardware LIFO feeding a register stage; pop_data/pop_valid drive its D/set.
// Define STACK36_ERR_EN to add the sticky overflow/underflow err flag.
module stack36 #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst_n,
  stack36_if.slave  s
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic [PTR_W:0]   count_m1;
  logic [WIDTH-1:0] pop_data_reg;
  logic             pop_valid_reg;
  logic             full_w;
  logic             empty_w;
  logic             pop_ok;
  logic             push_ok;
  logic [PTR_W-1:0] top_addr;
  logic [PTR_W-1:0] wr_addr;

  assign full_w   = (count_reg == DEPTH_C);
  assign empty_w  = (count_reg == '0);
  assign count_m1 = count_reg - ONE_C;
  assign top_addr = count_m1[PTR_W-1:0];

  // A push while full is still taken when a pop frees the top in the same cycle.
  assign pop_ok  = s.pop && !empty_w;
  assign push_ok = s.push && (!full_w || pop_ok);
  assign wr_addr = pop_ok ? top_addr : count_reg[PTR_W-1:0];

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok)
      count_next = count_reg + ONE_C;
    else if (pop_ok && !push_ok)
      count_next = count_m1;
  end

  // Storage is not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && !s.clr && push_ok)
      mem[wr_addr] <= s.push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      pop_valid_reg <= 1'b0;
      pop_data_reg  <= '0;
    end else if (s.clr) begin
      count_reg     <= '0;
      pop_valid_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      pop_valid_reg <= pop_ok;
      if (pop_ok)
        pop_data_reg <= mem[top_addr];
    end
  end

`ifdef STACK36_ERR_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_reg <= 1'b0;
    else if (s.clr)
      err_reg <= 1'b0;
    else if ((s.push && !push_ok) || (s.pop && !pop_ok))
      err_reg <= 1'b1;
  end

  assign s.err = err_reg;
`endif

  assign s.pop_data  = pop_data_reg;
  assign s.pop_valid = pop_valid_reg;
  assign s.full      = full_w;
  assign s.empty     = empty_w;
  assign s.count     = count_reg;

endmodule

// File: tb/tb_stack36.sv
// Self-checking bench for stack36: directed scenarios plus a randomized run
// against a queue-based LIFO model.
module tb_stack36;
  localparam int WIDTH = 36;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack36_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  stack36 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_data = '0;
  logic             m_valid = 1'b0;
  logic             m_err = 1'b0;

  // Apply one cycle of stimulus and advance the LIFO model.
  task automatic drive(input logic pu, input logic po, input logic cl, input logic [WIDTH-1:0] d);
    logic pop_acc, push_acc;
    bus.push = pu; bus.pop = po; bus.clr = cl; bus.push_data = d;
    @(posedge clk);
    if (cl) begin
      q.delete(); m_valid = 1'b0; m_err = 1'b0;
    end else begin
      pop_acc  = po && (q.size() > 0);
      push_acc = pu && ((q.size() < DEPTH) || pop_acc);
      m_valid  = pop_acc;
      if (pop_acc) m_data = q.pop_back();
      if (push_acc) q.push_back(d);
      if ((pu && !push_acc) || (po && !pop_acc)) m_err = 1'b1;
    end
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0;
    $display("txn t=%0t push=%b pop=%b clr=%b data=%h -> count=%0d pop_valid=%b pop_data=%h",
             $time, pu, po, cl, d, bus.count, bus.pop_valid, bus.pop_data);
  endtask

  task automatic test_reset;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0; bus.push_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.count !== 0) begin failures++; $display("FAIL reset_count act=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty act=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full act=%b exp=0", bus.full); end
    checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid act=%b exp=0", bus.pop_valid); end
    checks++; if (bus.pop_data !== 36'h0) begin failures++; $display("FAIL reset_pop_data act=%h exp=0", bus.pop_data); end
`ifdef STACK36_ERR_EN
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err act=%b exp=0", bus.err); end
`endif
  endtask

  task automatic test_push_pop;
    drive(1'b1, 1'b0, 1'b0, 36'h123456789);
    drive(1'b1, 1'b0, 1'b0, 36'hFEDCBA987);
    checks++; if (bus.count !== 2) begin failures++; $display("FAIL pp_count2 act=%0d exp=2", bus.count); end
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 36'hFEDCBA987)
      begin failures++; $display("FAIL pp_pop1 act=%b/%h exp=1/fedcba987", bus.pop_valid, bus.pop_data); end
    checks++; if (bus.count !== 1) begin failures++; $display("FAIL pp_count1 act=%0d exp=1", bus.count); end
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 36'h123456789)
      begin failures++; $display("FAIL pp_pop2 act=%b/%h exp=1/123456789", bus.pop_valid, bus.pop_data); end
    checks++; if (bus.count !== 0 || bus.empty !== 1'b1)
      begin failures++; $display("FAIL pp_empty act=%0d/%b exp=0/1", bus.count, bus.empty); end
    drive(1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.pop_valid !== 1'b0 || bus.pop_data !== 36'h123456789)
      begin failures++; $display("FAIL pp_strobe_hold act=%b/%h exp=0/123456789", bus.pop_valid, bus.pop_data); end
  endtask

  task automatic test_full;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 36'(i) * 36'h111111111);
    checks++; if (bus.full !== 1'b1 || bus.count !== 16)
      begin failures++; $display("FAIL full_set act=%b/%0d exp=1/16", bus.full, bus.count); end
    drive(1'b1, 1'b0, 1'b0, 36'hAAAAAAAAA);
    checks++; if (bus.full !== 1'b1 || bus.count !== 16)
      begin failures++; $display("FAIL full_overflow act=%b/%0d exp=1/16", bus.full, bus.count); end
`ifdef STACK36_ERR_EN
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL full_err act=%b exp=1", bus.err); end
`endif
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 36'hFFFFFFFFF || bus.count !== 15)
      begin failures++; $display("FAIL full_pop act=%b/%h/%0d exp=1/fffffffff/15", bus.pop_valid, bus.pop_data, bus.count); end
    drive(1'b0, 1'b0, 1'b1, '0);
    checks++; if (bus.count !== 0 || bus.empty !== 1'b1)
      begin failures++; $display("FAIL full_clr act=%0d/%b exp=0/1", bus.count, bus.empty); end
`ifdef STACK36_ERR_EN
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL full_clr_err act=%b exp=0", bus.err); end
`endif
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 1'b0, 36'(i));
    drive(1'b1, 1'b1, 1'b0, 36'h00000000F);
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 36'h3 || bus.count !== 3)
      begin failures++; $display("FAIL b2b_swap act=%b/%h/%0d exp=1/3/3", bus.pop_valid, bus.pop_data, bus.count); end
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 36'hF || bus.count !== 2)
      begin failures++; $display("FAIL b2b_next act=%b/%h/%0d exp=1/f/2", bus.pop_valid, bus.pop_data, bus.count); end
    drive(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_empty_pop;
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.pop_valid !== 1'b0 || bus.pop_data !== 36'hF || bus.count !== 0)
      begin failures++; $display("FAIL empty_pop act=%b/%h/%0d exp=0/f/0", bus.pop_valid, bus.pop_data, bus.count); end
`ifdef STACK36_ERR_EN
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL empty_err act=%b exp=1", bus.err); end
`endif
    drive(1'b1, 1'b1, 1'b0, 36'h5A5A5A5A5);
    checks++; if (bus.pop_valid !== 1'b0 || bus.count !== 1)
      begin failures++; $display("FAIL empty_pushpop act=%b/%0d exp=0/1", bus.pop_valid, bus.count); end
    drive(1'b1, 1'b1, 1'b1, 36'h1);
    checks++; if (bus.count !== 0 || bus.pop_valid !== 1'b0)
      begin failures++; $display("FAIL clr_priority act=%0d/%b exp=0/0", bus.count, bus.pop_valid); end
`ifdef STACK36_ERR_EN
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL clr_err act=%b exp=0", bus.err); end
`endif
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 36'(100 + i));
    drive(1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 36'd104)
      begin failures++; $display("FAIL ar_pre act=%b/%h exp=1/68", bus.pop_valid, bus.pop_data); end
    bus.pop = 1'b1;
    #2 rst_n = 1'b0;
    bus.push = 1'bx; bus.pop = 1'bx;
    #1;
    checks++; if (bus.count !== 0 || bus.pop_valid !== 1'b0 || bus.pop_data !== 36'h0)
      begin failures++; $display("FAIL ar_immediate act=%0d/%b/%h exp=0/0/0", bus.count, bus.pop_valid, bus.pop_data); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.count !== 0 || bus.pop_valid !== 1'b0)
      begin failures++; $display("FAIL ar_x_inputs act=%0d/%b exp=0/0", bus.count, bus.pop_valid); end
    bus.push = 1'b0; bus.pop = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    q.delete(); m_valid = 1'b0; m_data = '0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.pop_valid !== 1'b0 || bus.count !== 0)
        begin failures++; $display("FAIL ar_release cyc=%0d act=%b/%0d exp=0/0", i, bus.pop_valid, bus.count); end
    end
  endtask

  task automatic test_random;
    int push_pct, pop_pct;
    for (int i = 0; i < 400; i++) begin
      push_pct = (i < 100) ? 80 : (i < 200) ? 25 : (i < 300) ? 90 : 50;
      pop_pct  = (i < 100) ? 30 : (i < 200) ? 80 : (i < 300) ? 40 : 50;
      drive(($urandom_range(0, 99) < push_pct), ($urandom_range(0, 99) < pop_pct),
            ($urandom_range(0, 59) == 0), {$urandom(), $urandom()} & 36'hFFFFFFFFF);
      checks++; if (bus.count !== q.size())
        begin failures++; $display("FAIL rnd_count i=%0d act=%0d exp=%0d", i, bus.count, q.size()); end
      checks++; if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH))
        begin failures++; $display("FAIL rnd_flags i=%0d act=%b%b exp=%b%b", i, bus.empty, bus.full, q.size() == 0, q.size() == DEPTH); end
      checks++; if (bus.pop_valid !== m_valid || bus.pop_data !== m_data)
        begin failures++; $display("FAIL rnd_pop i=%0d act=%b/%h exp=%b/%h", i, bus.pop_valid, bus.pop_data, m_valid, m_data); end
`ifdef STACK36_ERR_EN
      checks++; if (bus.err !== m_err)
        begin failures++; $display("FAIL rnd_err i=%0d act=%b exp=%b", i, bus.err, m_err); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_back_to_back();
    test_empty_pop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
